// File: rtl/icache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int INS_WIDTH  = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOOKUP  = 2'd1,
      ST_REFILL  = 2'd2,
      ST_RESPOND = 2'd3
   } state_t;

   function automatic int tag_width(input int addr_w, input int index_bits);
      return addr_w - index_bits - 2;
   endfunction

endpackage

// File: rtl/icache_mem.sv
// Line storage for the instruction cache: valid/tag/data per line.
// Synchronous write, combinational read; reset clears only the valid bits.
module icache_mem
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = 8,
   parameter int TAG_W      = 22
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] w_index,
   input  logic [TAG_W-1:0]      w_tag,
   input  logic [INS_WIDTH-1:0]  w_data,
   input  logic [INDEX_BITS-1:0] r_index,
   output logic                  r_valid,
   output logic [TAG_W-1:0]      r_tag,
   output logic [INS_WIDTH-1:0]  r_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]     valid_q;
   logic [TAG_W-1:0]     tag_q  [LINES];
   logic [INS_WIDTH-1:0] data_q [LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[w_index] <= 1'b1;
      end
   end

   // Tag/data need no reset: a cleared valid bit masks them.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[w_index]  <= w_tag;
         data_q[w_index] <= w_data;
      end
   end

   assign r_valid = valid_q[r_index];
   assign r_tag   = tag_q[r_index];
   assign r_data  = data_q[r_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, refilled one
// byte at a time (little-endian) from a byte-wide memory port.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | ready for a request; response pulse (if any) visible here
// ST_LOOKUP  | compare latched tag against indexed line
// ST_REFILL  | read 4 bytes from memory, counter selects the byte
// ST_RESPOND | issue refilled word unless a flush arrived meanwhile
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = 8,
   parameter int ADDR_W     = ADDR_WIDTH
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 fetch2iCache_en,
   input  logic [ADDR_W-1:0]    fetch2iCache_address,
   output logic                 iCache_ready,
   output logic                 iCache2fetch_valid,
   output logic [INS_WIDTH-1:0] iCache2fetch_ins,
   input  logic                 flush_in,
   output logic                 iCache2mem_en,
   output logic [ADDR_W-1:0]    iCache2mem_addr,
   input  logic                 mem2iCache_valid,
   input  logic [7:0]           mem2iCache_byte
);

   localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);

   state_t state_q, state_d;

   logic [ADDR_W-1:0]     addr_q;
   logic [1:0]            cnt_q;
   logic [INS_WIDTH-1:0]  buf_q;
   logic                  flushed_q;
   logic                  valid_q;
   logic [INS_WIDTH-1:0]  ins_q;

   logic                  accept, hit_fire, take_byte, resp_fire;
   logic                  fill_done, line_we, hit;
   logic [INDEX_BITS-1:0] index;
   logic [TAG_W-1:0]      tag;
   logic                  line_valid;
   logic [TAG_W-1:0]      line_tag;
   logic [INS_WIDTH-1:0]  line_data;
   logic [INS_WIDTH-1:0]  fill_word;

   assign index = addr_q[INDEX_BITS+1:2];
   assign tag   = addr_q[ADDR_W-1:INDEX_BITS+2];
   assign hit   = line_valid && (line_tag == tag);

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      hit_fire  = 1'b0;
      take_byte = 1'b0;
      resp_fire = 1'b0;
      if (rdy_in) begin
         unique case (state_q)
            ST_IDLE: begin
               if (fetch2iCache_en && !flush_in) begin
                  accept  = 1'b1;
                  state_d = ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (flush_in) begin
                  state_d = ST_IDLE;
               end else if (hit) begin
                  hit_fire = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_REFILL;
               end
            end
            ST_REFILL: begin
               // Flush never abandons a memory transaction; it is only
               // remembered so the response can be dropped.
               if (mem2iCache_valid) begin
                  take_byte = 1'b1;
                  if (cnt_q == 2'd3) state_d = ST_RESPOND;
               end
            end
            ST_RESPOND: begin
               resp_fire = !flush_in && !flushed_q;
               state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign fill_done = take_byte && (cnt_q == 2'd3);
   assign line_we   = fill_done && !rst_in;
   assign fill_word = {mem2iCache_byte, buf_q[23:0]};

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         addr_q    <= '0;
         cnt_q     <= 2'd0;
         buf_q     <= '0;
         flushed_q <= 1'b0;
         valid_q   <= 1'b0;
         ins_q     <= '0;
      end else if (rdy_in) begin
         valid_q <= hit_fire || resp_fire;
         if (accept)    addr_q <= fetch2iCache_address;
         if (hit_fire)  ins_q  <= line_data;
         if (resp_fire) ins_q  <= buf_q;
         if (state_q == ST_LOOKUP) begin
            cnt_q     <= 2'd0;
            flushed_q <= 1'b0;
         end
         if (state_q == ST_REFILL && flush_in) flushed_q <= 1'b1;
         if (take_byte) begin
            buf_q[{cnt_q, 3'b000} +: 8] <= mem2iCache_byte;
            cnt_q <= cnt_q + 2'd1;
         end
      end
   end

   icache_mem #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W)
   ) u_mem (
      .clk     (clk_in),
      .rst     (rst_in),
      .we      (line_we),
      .w_index (index),
      .w_tag   (tag),
      .w_data  (fill_word),
      .r_index (index),
      .r_valid (line_valid),
      .r_tag   (line_tag),
      .r_data  (line_data)
   );

   assign iCache_ready       = (state_q == ST_IDLE);
   assign iCache2fetch_valid = valid_q;
   assign iCache2fetch_ins   = ins_q;
   assign iCache2mem_en      = (state_q == ST_REFILL);
   assign iCache2mem_addr    = {addr_q[ADDR_W-1:2], cnt_q};

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: misses, hits, conflict replacement, flush,
// rdy stall and reset mid-refill, with hand-computed expected values.
module tb_icache;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        fetch2iCache_en = 1'b0;
   logic [31:0] fetch2iCache_address = '0;
   logic        iCache_ready;
   logic        iCache2fetch_valid;
   logic [31:0] iCache2fetch_ins;
   logic        flush_in = 1'b0;
   logic        iCache2mem_en;
   logic [31:0] iCache2mem_addr;
   logic        mem2iCache_valid = 1'b0;
   logic [7:0]  mem2iCache_byte = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk_in = ~clk_in;

   icache dut (
      .clk_in               (clk_in),
      .rst_in               (rst_in),
      .rdy_in               (rdy_in),
      .fetch2iCache_en      (fetch2iCache_en),
      .fetch2iCache_address (fetch2iCache_address),
      .iCache_ready         (iCache_ready),
      .iCache2fetch_valid   (iCache2fetch_valid),
      .iCache2fetch_ins     (iCache2fetch_ins),
      .flush_in             (flush_in),
      .iCache2mem_en        (iCache2mem_en),
      .iCache2mem_addr      (iCache2mem_addr),
      .mem2iCache_valid     (mem2iCache_valid),
      .mem2iCache_byte      (mem2iCache_byte)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic request(input logic [31:0] a);
      check("ready_before_req", {31'b0, iCache_ready}, 32'd1);
      fetch2iCache_en      = 1'b1;
      fetch2iCache_address = a;
      @(negedge clk_in);
      fetch2iCache_en = 1'b0;
   endtask

   task automatic serve(input logic [31:0] a, input logic [7:0] b);
      int n = 0;
      while (iCache2mem_en !== 1'b1 && n < 8) begin
         @(negedge clk_in);
         n++;
      end
      check("mem_en_wait", {31'b0, iCache2mem_en}, 32'd1);
      check("mem_addr", iCache2mem_addr, a);
      mem2iCache_valid = 1'b1;
      mem2iCache_byte  = b;
      @(negedge clk_in);
      mem2iCache_valid = 1'b0;
   endtask

   task automatic expect_pulse(input logic [31:0] w);
      check("pulse_valid", {31'b0, iCache2fetch_valid}, 32'd1);
      check("pulse_ins", iCache2fetch_ins, w);
      @(negedge clk_in);
      check("pulse_end", {31'b0, iCache2fetch_valid}, 32'd0);
      check("ins_held", iCache2fetch_ins, w);
   endtask

   task automatic refill_and_respond(input logic [31:0] a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) serve(a + k, w[8*k +: 8]);
      check("mem_en_after_fill", {31'b0, iCache2mem_en}, 32'd0);
      check("no_early_valid", {31'b0, iCache2fetch_valid}, 32'd0);
      @(negedge clk_in);
      expect_pulse(w);
   endtask

   initial begin
      int pulses;

      // Reset state
      @(negedge clk_in);
      @(negedge clk_in);
      check("rst_valid", {31'b0, iCache2fetch_valid}, 32'd0);
      check("rst_ins", iCache2fetch_ins, 32'd0);
      check("rst_mem_en", {31'b0, iCache2mem_en}, 32'd0);
      check("rst_mem_addr", iCache2mem_addr, 32'd0);
      check("rst_ready", {31'b0, iCache_ready}, 32'd1);
      rst_in = 1'b0;
      @(negedge clk_in);

      // Cold miss at 0x0
      request(32'h0000_0000);
      refill_and_respond(32'h0000_0000, 32'h0000_0513);

      // Hit at 0x0: pulse two cycles after acceptance, no memory traffic
      request(32'h0000_0000);
      check("hit_no_mem", {31'b0, iCache2mem_en}, 32'd0);
      check("hit_not_yet", {31'b0, iCache2fetch_valid}, 32'd0);
      @(negedge clk_in);
      check("hit_no_mem2", {31'b0, iCache2mem_en}, 32'd0);
      expect_pulse(32'h0000_0513);

      // Conflict: 0x400 replaces index 0, then 0x0 misses again
      request(32'h0000_0400);
      refill_and_respond(32'h0000_0400, 32'h0010_0093);
      request(32'h0000_0000);
      refill_and_respond(32'h0000_0000, 32'h0000_0513);

      // Flush together with a request in IDLE is ignored
      fetch2iCache_en      = 1'b1;
      fetch2iCache_address = 32'h0000_0000;
      flush_in             = 1'b1;
      @(negedge clk_in);
      fetch2iCache_en = 1'b0;
      flush_in        = 1'b0;
      check("flush_req_ready", {31'b0, iCache_ready}, 32'd1);
      @(negedge clk_in);
      check("flush_req_no_pulse", {31'b0, iCache2fetch_valid}, 32'd0);

      // Flush after the 2nd refill byte: refill completes, pulse dropped
      request(32'h0000_0800);
      serve(32'h0000_0800, 8'h37);
      serve(32'h0000_0801, 8'h12);
      flush_in = 1'b1;
      @(negedge clk_in);
      flush_in = 1'b0;
      serve(32'h0000_0802, 8'h00);
      serve(32'h0000_0803, 8'h00);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (iCache2fetch_valid === 1'b1) pulses++;
         @(negedge clk_in);
      end
      check("flush_pulses", pulses, 32'd0);
      request(32'h0000_0800);
      check("flush_line_hit", {31'b0, iCache2mem_en}, 32'd0);
      @(negedge clk_in);
      expect_pulse(32'h0000_1237);

      // rdy_in low for 3 cycles with a byte pending during refill
      request(32'h0000_0C04);
      serve(32'h0000_0C04, 8'hAA);
      rdy_in           = 1'b0;
      mem2iCache_valid = 1'b1;
      mem2iCache_byte  = 8'hBB;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         check("stall_addr", iCache2mem_addr, 32'h0000_0C05);
         check("stall_en", {31'b0, iCache2mem_en}, 32'd1);
      end
      rdy_in = 1'b1;
      @(negedge clk_in);
      mem2iCache_valid = 1'b0;
      check("resume_addr", iCache2mem_addr, 32'h0000_0C06);
      serve(32'h0000_0C06, 8'hCC);
      serve(32'h0000_0C07, 8'hDD);
      check("stall_fill_done", {31'b0, iCache2mem_en}, 32'd0);
      @(negedge clk_in);
      expect_pulse(32'hDDCC_BBAA);

      // Reset mid-refill
      request(32'h0000_1008);
      serve(32'h0000_1008, 8'h11);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check("mrst_valid", {31'b0, iCache2fetch_valid}, 32'd0);
      check("mrst_ins", iCache2fetch_ins, 32'd0);
      check("mrst_mem_en", {31'b0, iCache2mem_en}, 32'd0);
      check("mrst_mem_addr", iCache2mem_addr, 32'd0);
      check("mrst_ready", {31'b0, iCache_ready}, 32'd1);
      request(32'h0000_1008);
      refill_and_respond(32'h0000_1008, 32'h4433_2211);
      // Reset cleared every line, including the one written before it
      request(32'h0000_0800);
      refill_and_respond(32'h0000_0800, 32'h0000_1237);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
